// File: rtl/branch_predictor_btb.sv
// Dynamic branch predictor: tagged BTB plus saturating direction counters, one-cycle lookup.
// Optional gshare counter indexing is enabled by defining BPRED_GSHARE_EN.
module branch_predictor_btb #(
    parameter int ADDR_W   = 32,
    parameter int ENTRIES  = 64,
    parameter int TAG_W    = 8,
    parameter int CTR_BITS = 2,
    parameter int GHR_BITS = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              lu_valid_i,
    input  logic              lu_stall_i,
    input  logic              lu_flush_i,
    input  logic [ADDR_W-1:0] lu_pc_i,
    output logic              pred_valid_o,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_mispredict_i,
    output logic [31:0]       stat_lookups_o,
    output logic [31:0]       stat_mispredicts_o
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));

    logic                valid_q  [ENTRIES];
    logic                valid_d  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [TAG_W-1:0]    tag_d    [ENTRIES];
    logic [ADDR_W-1:0]   target_q [ENTRIES];
    logic [ADDR_W-1:0]   target_d [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d    [ENTRIES];

    logic [IDX_W-1:0] lu_idx, upd_idx, lu_cidx, upd_cidx;
    logic [TAG_W-1:0] lu_tag, upd_tag;
    logic             upd_hit, lu_hit, lu_taken, lu_accept;
    logic [ADDR_W-1:0] lu_target;

    logic              pred_valid_q, pred_hit_q, pred_taken_q;
    logic [ADDR_W-1:0] pred_target_q;
    logic [31:0]       stat_lookups_q, stat_mispredicts_q;

    logic unused_upd_pc;
    assign unused_upd_pc = ^upd_pc_i;

    assign lu_idx  = lu_pc_i[IDX_W+1:2];
    assign lu_tag  = lu_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

`ifdef BPRED_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q;

    // Both ports hash with the pre-update history, so the bypass sees matching indices.
    assign lu_cidx  = lu_idx ^ IDX_W'(ghr_q);
    assign upd_cidx = upd_idx ^ IDX_W'(ghr_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ghr_q <= '0;
        end else if (upd_valid_i) begin
            ghr_q <= GHR_BITS'({ghr_q, upd_taken_i});
        end
    end
`else
    assign lu_cidx  = lu_idx;
    assign upd_cidx = upd_idx;
`endif

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        if (upd_valid_i) begin
            if (upd_hit) begin
                if (upd_taken_i) begin
                    target_d[upd_idx] = upd_target_i;
                    if (ctr_q[upd_cidx] != CTR_MAX) begin
                        ctr_d[upd_cidx] = ctr_q[upd_cidx] + CTR_BITS'(1);
                    end
                end else if (ctr_q[upd_cidx] != '0) begin
                    ctr_d[upd_cidx] = ctr_q[upd_cidx] - CTR_BITS'(1);
                end
            end else if (upd_taken_i) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target_i;
                ctr_d[upd_cidx]   = CTR_WT;
            end
        end
    end

    // Lookup reads the post-update table: same-edge updates are visible (write-first).
    assign lu_hit    = valid_d[lu_idx] && (tag_d[lu_idx] == lu_tag);
    assign lu_taken  = lu_hit && ctr_d[lu_cidx][CTR_BITS-1];
    assign lu_target = lu_taken ? target_d[lu_idx] : lu_pc_i + ADDR_W'(4);
    assign lu_accept = lu_valid_i && !lu_stall_i && !lu_flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= valid_d[i];
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else if (lu_flush_i) begin
            pred_valid_q <= 1'b0;
        end else if (!lu_stall_i) begin
            pred_valid_q <= lu_valid_i;
            if (lu_valid_i) begin
                pred_hit_q    <= lu_hit;
                pred_taken_q  <= lu_taken;
                pred_target_q <= lu_target;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_lookups_q     <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (lu_accept && (stat_lookups_q != '1)) begin
                stat_lookups_q <= stat_lookups_q + 32'd1;
            end
            if (upd_valid_i && upd_mispredict_i && (stat_mispredicts_q != '1)) begin
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
            end
        end
    end

    assign pred_valid_o       = pred_valid_q;
    assign pred_hit_o         = pred_hit_q;
    assign pred_taken_o       = pred_taken_q;
    assign pred_target_o      = pred_target_q;
    assign stat_lookups_o     = stat_lookups_q;
    assign stat_mispredicts_o = stat_mispredicts_q;
endmodule
